// File: rtl/gtp_link_seq.sv
// rtl/gtp_link_seq.sv - GTP link bring-up sequencer: tile reset, StartComm, retry/backoff, Gen2->Gen1 fallback
// Optional feature: GTP_LINK_SEQ_HOTPLUG_EN (COMINIT in S_FAIL restarts bring-up at Gen2).
module gtp_link_seq #(
    parameter int C_RST_CYC   = 16,
    parameter int C_PLL_TO    = 65535,
    parameter int C_START_CYC = 32,
    parameter int C_LINK_TO   = 524287,
    parameter int C_BACKOFF   = 4096,
    parameter int C_MAX_RETRY = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       port_start,
    input  logic       plllkdet,
    input  logic       tx_sync_done,
    input  logic       link_up,
    input  logic       comm_init,
    output logic       gtp_reset,
    output logic       start_comm,
    output logic       spd_gen2,
    output logic       link_ready,
    output logic       link_fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] seq_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESET     = 3'd1;
    localparam logic [2:0] S_WAIT_PLL  = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT_LINK = 3'd4;
    localparam logic [2:0] S_UP        = 3'd5;
    localparam logic [2:0] S_BACKOFF   = 3'd6;
    localparam logic [2:0] S_FAIL      = 3'd7;

    // Timer value seen on the last cycle of each timed dwell.
    localparam logic [19:0] RST_LAST     = 20'(C_RST_CYC - 1);
    localparam logic [19:0] PLL_LAST     = 20'(C_PLL_TO - 1);
    localparam logic [19:0] START_LAST   = 20'(C_START_CYC - 1);
    localparam logic [19:0] LINK_LAST    = 20'(C_LINK_TO - 1);
    localparam logic [19:0] BACKOFF_LAST = 20'(C_BACKOFF - 1);
    localparam logic [4:0]  MAX_RETRY5   = 5'(C_MAX_RETRY);
    localparam logic [3:0]  MAX_RETRY4   = 4'(C_MAX_RETRY);

    logic [2:0]  state_q;
    logic [2:0]  state_ns;
    logic [19:0] timer_q;
    logic        spd_ns;
    logic [3:0]  retry_ns;
    logic        fail_ev;

`ifndef GTP_LINK_SEQ_HOTPLUG_EN
    logic unused_comm_init;
    assign unused_comm_init = comm_init;
`endif

    always_comb begin
        state_ns = state_q;
        spd_ns   = spd_gen2;
        retry_ns = retry_cnt;
        fail_ev  = 1'b0;
        case (state_q)
            S_IDLE:      if (port_start) state_ns = S_RESET;
            S_RESET:     if (timer_q == RST_LAST) state_ns = S_WAIT_PLL;
            S_WAIT_PLL: begin
                if (plllkdet && tx_sync_done) state_ns = S_START;
                else if (timer_q == PLL_LAST) fail_ev = 1'b1;
            end
            S_START:     if (timer_q == START_LAST) state_ns = S_WAIT_LINK;
            S_WAIT_LINK: begin
                // link_up beats a coincident timeout
                if (link_up) begin
                    state_ns = S_UP;
                    retry_ns = 4'd0;
                end else if (timer_q == LINK_LAST) begin
                    fail_ev = 1'b1;
                end
            end
            S_UP:        if (!link_up) state_ns = S_START;
            S_BACKOFF:   if (timer_q == BACKOFF_LAST) state_ns = S_START;
            S_FAIL: begin
`ifdef GTP_LINK_SEQ_HOTPLUG_EN
                if (comm_init) begin
                    state_ns = S_RESET;
                    spd_ns   = 1'b1;
                    retry_ns = 4'd0;
                end
`else
                state_ns = S_FAIL;
`endif
            end
            default:     state_ns = S_IDLE;
        endcase

        if (fail_ev) begin
            if (({1'b0, retry_cnt} + 5'd1) < MAX_RETRY5) begin
                retry_ns = retry_cnt + 4'd1;
                state_ns = S_BACKOFF;
            end else if (spd_gen2) begin
                // a line-rate change needs a fresh tile reset
                spd_ns   = 1'b0;
                retry_ns = 4'd0;
                state_ns = S_RESET;
            end else begin
                retry_ns = MAX_RETRY4;
                state_ns = S_FAIL;
            end
        end

        if (!port_start) state_ns = S_IDLE;

        if (state_ns == S_IDLE) begin
            spd_ns   = 1'b1;
            retry_ns = 4'd0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= 20'd0;
            spd_gen2   <= 1'b1;
            retry_cnt  <= 4'd0;
            gtp_reset  <= 1'b1;
            start_comm <= 1'b1;
            link_ready <= 1'b0;
            link_fail  <= 1'b0;
        end else begin
            state_q   <= state_ns;
            spd_gen2  <= spd_ns;
            retry_cnt <= retry_ns;
            if (state_ns != state_q)
                timer_q <= 20'd0;
            else if (timer_q != 20'hFFFFF)
                timer_q <= timer_q + 20'd1;
            gtp_reset  <= (state_ns == S_IDLE) || (state_ns == S_RESET);
            start_comm <= !((state_ns == S_WAIT_LINK) || (state_ns == S_UP));
            link_ready <= (state_ns == S_UP);
            link_fail  <= (state_ns == S_FAIL);
        end
    end

    assign seq_state = state_q;

endmodule

// File: tb/tb_gtp_link_seq.sv
// tb/tb_gtp_link_seq.sv - directed plus randomized bench for gtp_link_seq against a dwell-count model
module tb_gtp_link_seq;

    localparam int RST_CYC   = 4;
    localparam int PLL_TO    = 16;
    localparam int START_CYC = 8;
    localparam int LINK_TO   = 64;
    localparam int BACKOFF   = 10;
    localparam int MAX_RETRY = 2;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       port_start;
    logic       plllkdet;
    logic       tx_sync_done;
    logic       link_up;
    logic       comm_init;
    logic       gtp_reset;
    logic       start_comm;
    logic       spd_gen2;
    logic       link_ready;
    logic       link_fail;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    int n_chk  = 0;
    int n_pass = 0;
    int n_prt  = 0;
    bit cmp_en = 0;

    gtp_link_seq #(
        .C_RST_CYC  (RST_CYC),
        .C_PLL_TO   (PLL_TO),
        .C_START_CYC(START_CYC),
        .C_LINK_TO  (LINK_TO),
        .C_BACKOFF  (BACKOFF),
        .C_MAX_RETRY(MAX_RETRY)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .port_start  (port_start),
        .plllkdet    (plllkdet),
        .tx_sync_done(tx_sync_done),
        .link_up     (link_up),
        .comm_init   (comm_init),
        .gtp_reset   (gtp_reset),
        .start_comm  (start_comm),
        .spd_gen2    (spd_gen2),
        .link_ready  (link_ready),
        .link_fail   (link_fail),
        .retry_cnt   (retry_cnt),
        .seq_state   (seq_state)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Model: phase number, edges spent in the phase, current speed and failure count.
    int m_ph  = 0;
    int m_age = 0;
    int m_gen = 1;
    int m_try = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_ph = 0; m_age = 0; m_gen = 1; m_try = 0;
        end else begin
            int dwell;
            int nxt;
            bit failed;
            dwell  = m_age + 1;
            nxt    = m_ph;
            failed = 0;
            case (m_ph)
                0: if (port_start) nxt = 1;
                1: if (dwell >= RST_CYC) nxt = 2;
                2: if (plllkdet && tx_sync_done) nxt = 3;
                   else if (dwell >= PLL_TO) failed = 1;
                3: if (dwell >= START_CYC) nxt = 4;
                4: if (link_up) begin nxt = 5; m_try = 0; end
                   else if (dwell >= LINK_TO) failed = 1;
                5: if (!link_up) nxt = 3;
                6: if (dwell >= BACKOFF) nxt = 3;
                default: begin
`ifdef GTP_LINK_SEQ_HOTPLUG_EN
                    if (comm_init) begin nxt = 1; m_gen = 1; m_try = 0; end
`endif
                end
            endcase
            if (failed) begin
                if (m_try + 1 < MAX_RETRY) begin m_try++; nxt = 6; end
                else if (m_gen == 1) begin m_gen = 0; m_try = 0; nxt = 1; end
                else begin m_try = MAX_RETRY; nxt = 7; end
            end
            if (!port_start) nxt = 0;
            if (nxt == 0) begin m_gen = 1; m_try = 0; end
            m_age = (nxt != m_ph) ? 0 : m_age + 1;
            m_ph  = nxt;
        end
    end

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            logic [11:0] act;
            logic [11:0] exp;
            act = {gtp_reset, start_comm, spd_gen2, link_ready, link_fail, retry_cnt, seq_state};
            exp = {(m_ph <= 1), !(m_ph == 4 || m_ph == 5), m_gen[0], (m_ph == 5), (m_ph == 7),
                   4'(m_try), 3'(m_ph)};
            n_chk++;
            if (act === exp) n_pass++;
            else if (n_prt < 40) begin
                n_prt++;
                $display("FAIL model_cmp t=%0t: got rst/sc/g2/rdy/fail/retry/st=%b expected %b",
                         $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick_in();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(seq_state) != s && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk(name, int'(seq_state), s);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gtp_reset"},  int'(gtp_reset),  1);
        chk({tag, "_start_comm"}, int'(start_comm), 1);
        chk({tag, "_spd_gen2"},   int'(spd_gen2),   1);
        chk({tag, "_link_ready"}, int'(link_ready), 0);
        chk({tag, "_link_fail"},  int'(link_fail),  0);
        chk({tag, "_retry_cnt"},  int'(retry_cnt),  0);
        chk({tag, "_seq_state"},  int'(seq_state),  0);
    endtask

    initial begin
        int c_rst;
        int c_start;
        int c_dw;
        sys_rst_n = 1'b1; port_start = 0; plllkdet = 0; tx_sync_done = 0;
        link_up = 0; comm_init = 0;
        #2 sys_rst_n = 1'b0;
        cmp_en = 1;
        repeat (3) @(negedge sys_clk);
        chk_reset_vals("por");
        tick_in(); sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // happy path
        tick_in(); port_start = 1; plllkdet = 1; tx_sync_done = 1;
        c_rst = 0; c_start = 0; c_dw = 0;
        while (seq_state != 3'd4 && c_dw < 100) begin
            @(negedge sys_clk);
            c_dw++;
            if (gtp_reset && seq_state != 3'd0) c_rst++;
            if (start_comm && seq_state == 3'd3) c_start++;
        end
        chk("t1_reach_wait_link", int'(seq_state), 4);
        chk("t1_gtp_reset_cycles", c_rst, 4);
        chk("t1_start_comm_cycles", c_start, 8);
        repeat (19) @(negedge sys_clk);
        tick_in(); link_up = 1;
        wait_state(5, 10, "t1_reach_up");
        chk("t1_link_ready", int'(link_ready), 1);
        chk("t1_spd_gen2", int'(spd_gen2), 1);
        chk("t1_retry_cnt", int'(retry_cnt), 0);

        // link drop and recovery
        tick_in(); link_up = 0;
        repeat (2) @(negedge sys_clk);
        chk("t3_link_ready", int'(link_ready), 0);
        chk("t3_start_comm", int'(start_comm), 1);
        chk("t3_seq_state", int'(seq_state), 3);
        tick_in(); link_up = 1;
        wait_state(5, 20, "t3_back_up");

        // abort from S_WAIT_LINK
        tick_in(); link_up = 0;
        wait_state(4, 20, "t5_reach_wait_link");
        tick_in(); port_start = 0;
        repeat (2) @(negedge sys_clk);
        chk("t5_abort_state", int'(seq_state), 0);

        // fallback and final failure
        tick_in(); port_start = 1;
        wait_state(6, 200, "t2_reach_backoff");
        c_dw = 0;
        while (seq_state == 3'd6 && c_dw < 40) begin c_dw++; @(negedge sys_clk); end
        chk("t2_backoff_cycles", c_dw, 10);
        wait_state(1, 200, "t2_reset_on_fallback");
        chk("t2_spd_gen2_fell", int'(spd_gen2), 0);
        chk("t2_retry_cleared", int'(retry_cnt), 0);
        wait_state(7, 400, "t2_reach_fail");
        chk("t2_link_fail", int'(link_fail), 1);
        chk("t2_retry_cnt", int'(retry_cnt), 2);

        // COMINIT in S_FAIL
        tick_in(); comm_init = 1;
        repeat (2) @(negedge sys_clk);
`ifdef GTP_LINK_SEQ_HOTPLUG_EN
        chk("t6_hotplug_state", int'(seq_state), 1);
        chk("t6_hotplug_spd", int'(spd_gen2), 1);
        chk("t6_hotplug_fail", int'(link_fail), 0);
`else
        chk("t6_sticky_state", int'(seq_state), 7);
        chk("t6_sticky_fail", int'(link_fail), 1);
`endif
        tick_in(); comm_init = 0;

        // PLL timeout
        tick_in(); port_start = 0; plllkdet = 0;
        tick_in(); port_start = 1;
        wait_state(2, 20, "t4_reach_wait_pll");
        c_dw = 0;
        while (seq_state == 3'd2 && c_dw < 40) begin c_dw++; @(negedge sys_clk); end
        chk("t4_pll_cycles", c_dw, 16);
        chk("t4_seq_state", int'(seq_state), 6);
        chk("t4_retry_cnt", int'(retry_cnt), 1);

        // asynchronous reset from S_UP
        tick_in(); plllkdet = 1; link_up = 1;
        wait_state(5, 60, "t5_reach_up");
        #2 sys_rst_n = 1'b0;
        #1 chk_reset_vals("async");
        tick_in(); sys_rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            tick_in();
            port_start   = ($urandom % 64) != 0;
            plllkdet     = ($urandom % 8) != 0;
            tx_sync_done = ($urandom % 8) != 0;
            if (($urandom % 24) == 0) link_up = ~link_up;
            comm_init    = ($urandom % 32) == 0;
        end
        @(negedge sys_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
